// File: rtl/apb_slave_regfile.sv
// APB3 completer exposing eight RW scratch registers, a read-only ID word and
// a read-only count of successful writes. Illegal accesses answer with
// pslverr. An optional fixed number of wait states stretches every ACCESS
// phase so that masters exercise the pready handshake.

// One scratch register; the top instantiates an array of these.
module apb_regfile_word #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    // Capture write data only on a completed, error-free write to this word.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) q <= '0;
        else if (we)  q <= d;
    end
endmodule

module apb_slave_regfile #(
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  ADDR_WIDTH  = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE  = 32'hA9B0_0001
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] W_NUM_REGS = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0] W_ID       = IDX_W'(8);
    localparam logic [IDX_W-1:0] W_CNT      = IDX_W'(9);
    localparam logic [3:0]       WS         = 4'(WAIT_STATES);

    // Decoded view of the current address/direction.
    typedef struct packed {
        logic       hit_reg;
        logic       hit_id;
        logic       hit_cnt;
        logic       err;
        logic [2:0] sel;
    } dec_t;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]                 reg_we;
    logic [DATA_WIDTH-1:0]               wr_cnt;
    logic [DATA_WIDTH-1:0]               rd_word;
    logic [3:0]                          wait_cnt;
    logic [IDX_W-1:0]                    word;
    logic                                acc;
    logic                                done;
    logic                                wr_done;
    dec_t                                dec;

    // Reset gates the bus so an aborted transfer can never complete.
    assign acc  = pselx & penable & presetn;
    assign word = paddr[ADDR_WIDTH-1:2];

    // Address decode and error classification for the current cycle.
    always_comb begin
        dec         = '0;
        dec.hit_reg = (word < W_NUM_REGS);
        dec.hit_id  = (word == W_ID);
        dec.hit_cnt = (word == W_CNT);
        dec.sel     = word[2:0];
        dec.err     = (paddr[1:0] != 2'b00)
                    | ~(dec.hit_reg | dec.hit_id | dec.hit_cnt)
                    | (pwrite & (dec.hit_id | dec.hit_cnt));
    end

    assign pready  = acc & (wait_cnt == WS);
    assign done    = acc & pready;
    assign pslverr = done & dec.err;
    assign wr_done = done & pwrite & ~dec.err;

    // Wait counter runs only while an ACCESS is being stretched.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)            wait_cnt <= '0;
        else if (acc && !pready) wait_cnt <= wait_cnt + 4'd1;
        else                     wait_cnt <= '0;
    end

    // Per-register write enables and storage.
    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_reg
            assign reg_we[i] = wr_done & dec.hit_reg & (dec.sel == 3'(i));
        end
    endgenerate

    apb_regfile_word #(.DATA_WIDTH(DATA_WIDTH)) u_word [NUM_REGS-1:0] (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (reg_we),
        .d       (pwdata),
        .q       (regs)
    );

    // Count successful scratch writes; wraps naturally at full scale.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                   wr_cnt <= '0;
        else if (wr_done && dec.hit_reg) wr_cnt <= wr_cnt + 1'b1;
    end

    // Read mux for whichever word is addressed.
    always_comb begin
        rd_word = '0;
        if (dec.hit_reg)      rd_word = regs[dec.sel];
        else if (dec.hit_id)  rd_word = ID_VALUE;
        else if (dec.hit_cnt) rd_word = wr_cnt;
    end

    // prdata is driven only for a completing, error-free read; zero otherwise.
    always_comb begin
        prdata = '0;
        if (done && !pwrite && !dec.err) prdata = rd_word;
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 2 wait states) share one
// APB master, steered by 'sel'. Stimulus pushes expected responses into a
// queue; a negedge monitor pops and checks each completed transfer.
module tb_apb_slave_regfile;
    logic        pclk = 1'b0;
    logic        presetn;
    logic [7:0]  paddr;
    logic        pselx, penable, pwrite;
    logic [31:0] pwdata;
    int          sel;

    logic [31:0] prdata0, prdata1, prdata_m;
    logic        pready0, pready1, pready_m;
    logic        pslverr0, pslverr1, pslverr_m;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        err;
        int          ws;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   waits  = 0;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.WAIT_STATES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr),
        .pselx(pselx && sel == 0), .penable(penable && sel == 0),
        .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_regfile #(.WAIT_STATES(2)) dut1 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr),
        .pselx(pselx && sel == 1), .penable(penable && sel == 1),
        .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    assign prdata_m  = (sel == 1) ? prdata1  : prdata0;
    assign pready_m  = (sel == 1) ? pready1  : pready0;
    assign pslverr_m = (sel == 1) ? pslverr1 : pslverr0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every completed transfer is checked against the queue head.
    always @(negedge pclk) begin
        if (!presetn) begin
            waits = 0;
        end else if (pselx && penable) begin
            if (pready_m) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got addr 0x%02h expected none", paddr);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, "/pslverr"}, 32'(pslverr_m), 32'(e.err));
                    chk({e.name, "/prdata"},  prdata_m, e.rd);
                    chk({e.name, "/waits"},   32'(waits), 32'(e.ws));
                end
                waits = 0;
            end else begin
                waits++;
            end
        end
    end

    // One transfer; entered and left at posedge+1 so back-to-back has no idle.
    task automatic xfer(input string nm, input bit w, input logic [7:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        int   n;
        e.name = nm; e.rd = exp_rd; e.err = exp_err; e.ws = (sel == 1) ? 2 : 0;
        q.push_back(e);
        pselx = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 0;
        forever begin
            @(negedge pclk);
            if (pready_m) break;
            n++;
            if (n >= 20) break;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s/timeout: got no pready expected within 20 cycles", nm);
            if (q.size() != 0) void'(q.pop_front());
        end
        @(posedge pclk); #1;
        pselx = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [7:0] a, input logic [31:0] d, input bit err);
        xfer(nm, 1'b1, a, d, 32'h0, err);
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] exp, input bit err);
        xfer(nm, 1'b0, a, 32'h0, exp, err);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        sel = 0; paddr = '0; pwrite = 1'b0; pwdata = '0;
        // Reset with the bus held in ACCESS: outputs must stay quiet.
        presetn = 1'b0; pselx = 1'b1; penable = 1'b1;
        #12;
        chk("rst/pready",  32'(pready_m),  32'h0);
        chk("rst/pslverr", 32'(pslverr_m), 32'h0);
        chk("rst/prdata",  prdata_m,       32'h0);
        pselx = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        idle(1);

        // Zero-wait instance: basic RW, ID, errors.
        rd("rst_cnt",  8'h24, 32'h0, 1'b0);
        wr("wr08",     8'h08, 32'hDEAD_BEEF, 1'b0);
        rd("rd08",     8'h08, 32'hDEAD_BEEF, 1'b0);
        rd("rd0c",     8'h0C, 32'h0, 1'b0);
        rd("cnt1",     8'h24, 32'h1, 1'b0);
        rd("id",       8'h20, 32'hA9B0_0001, 1'b0);
        wr("wr_id",    8'h20, 32'h1234, 1'b1);
        rd("id_again", 8'h20, 32'hA9B0_0001, 1'b0);
        rd("cnt_id",   8'h24, 32'h1, 1'b0);
        rd("unal02",   8'h02, 32'h0, 1'b1);
        rd("unmap40",  8'h40, 32'h0, 1'b1);
        rd("unmap28",  8'h28, 32'h0, 1'b1);
        wr("wr_fc",    8'hFC, 32'hFFFF_FFFF, 1'b1);
        wr("wr_cnt",   8'h24, 32'h5, 1'b1);
        wr("wr_unal",  8'h09, 32'h0BAD_0BAD, 1'b1);
        rd("rd08_keep",8'h08, 32'hDEAD_BEEF, 1'b0);
        rd("rd1c",     8'h1C, 32'h0, 1'b0);
        rd("cnt_err",  8'h24, 32'h1, 1'b0);
        idle(2);

        // Reset asserted inside a zero-wait ACCESS: write must be dropped.
        pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hCAFE_F00D;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2;
        presetn = 1'b0;
        #1;
        chk("midrst/pready",  32'(pready_m),  32'h0);
        chk("midrst/pslverr", 32'(pslverr_m), 32'h0);
        chk("midrst/prdata",  prdata_m,       32'h0);
        @(posedge pclk); #1;
        pselx = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) rd($sformatf("clr%0d", i), 8'(4 * i), 32'h0, 1'b0);
        rd("clr_cnt", 8'h24, 32'h0, 1'b0);

        // Two-wait instance: stretched handshake and back-to-back traffic.
        sel = 1;
        idle(1);
        rd("ws_rd00", 8'h00, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) wr($sformatf("b2b_wr%0d", i), 8'(4 * i), 32'(8'h11 * i), 1'b0);
        for (int i = 0; i < 8; i++) rd($sformatf("b2b_rd%0d", i), 8'(4 * i), 32'(8'h11 * i), 1'b0);
        rd("b2b_cnt", 8'h24, 32'h8, 1'b0);
        rd("ws_id",   8'h20, 32'hA9B0_0001, 1'b0);
        wr("ws_err",  8'h22, 32'h1, 1'b1);
        rd("ws_cnt2", 8'h24, 32'h8, 1'b0);
        idle(3);

        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finish");
        $fatal(1, "timeout");
    end
endmodule
